// File: rtl/rle_pixel_decoder_if.sv
// Reader-to-decoder handshake bundle.
//   instruction : {color, count} word presented by the flash reader
//   valid       : level, high while instruction holds an unconsumed word
//   shift_data  : one-cycle pulse from the decoder, word consumed
// master = flash reader side, slave = decoder side.
interface rle_pixel_decoder_if #(
    parameter int COLOR_W = 6,
    parameter int COUNT_W = 12
);
    logic [COLOR_W+COUNT_W-1:0] instruction;
    logic                       valid;
    logic                       shift_data;

    modport master (output instruction, output valid, input shift_data);
    modport slave  (input instruction, input valid, output shift_data);
endinterface

// File: rtl/rle_pixel_decoder.sv
// Run-length pixel decoder between the QSPI flash reader and the VGA stage.
// Holds one active run plus one prefetched instruction so the reader's
// refill latency is hidden behind the run currently being drawn.
//   clk          : pixel clock
//   rst          : asynchronous, active-high reset
//   reader       : instruction/valid in, shift_data out (slave modport)
//   video_active : a visible pixel is wanted this cycle
//   rgb          : registered pixel colour, 0 in blanking or underflow
//   underflow    : sticky, a pixel was wanted with no run loaded
module rle_pixel_decoder #(
    parameter int COLOR_W = 6,
    parameter int COUNT_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    rle_pixel_decoder_if.slave   reader,
    input  logic                 video_active,
    output logic [COLOR_W-1:0]   rgb,
    output logic                 underflow
);
    localparam logic [1:0] ARMED = 2'd0;
    localparam logic [1:0] ACK   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]         state;

    logic               pf_full;
    logic [COLOR_W-1:0] pf_color;
    logic [COUNT_W-1:0] pf_count;

    logic               cur_full;
    logic [COLOR_W-1:0] cur_color;
    logic [COUNT_W-1:0] cur_remain;

    logic run_end;
    logic pf_take;
    logic capture;

    // Last pixel of the current run is being emitted this cycle.
    assign run_end = video_active && cur_full && (cur_remain == '0);

    // Prefetch slot moves into the run engine: either the engine is idle,
    // or the current run ends now and the next one follows with no gap.
    assign pf_take = pf_full && (!cur_full || run_end);

    // A slot being emptied this cycle can accept a new word at the same edge.
    assign capture = (state == ARMED) && reader.valid && (!pf_full || pf_take);

    // Combinational from state so an async reset drops a pulse in flight.
    assign reader.shift_data = (state == ACK);

    // Fetch FSM. DRAIN waits for valid to fall so the stale word the reader
    // keeps presenting after shift_data is never captured twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARMED;
        end else begin
            case (state)
                ARMED:   if (capture) state <= ACK;
                ACK:     state <= DRAIN;
                DRAIN:   if (!reader.valid) state <= ARMED;
                default: state <= ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_full  <= 1'b0;
            pf_color <= '0;
            pf_count <= '0;
        end else if (capture) begin
            pf_full               <= 1'b1;
            {pf_color, pf_count}  <= reader.instruction;
        end else if (pf_take) begin
            pf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb        <= '0;
            underflow  <= 1'b0;
            cur_full   <= 1'b0;
            cur_color  <= '0;
            cur_remain <= '0;
        end else begin
            if (video_active) begin
                if (cur_full) begin
                    rgb <= cur_color;
                    if (cur_remain != '0) cur_remain <= cur_remain - COUNT_W'(1);
                end else begin
                    rgb       <= '0;
                    underflow <= 1'b1;
                end
            end else begin
                rgb <= '0;
            end

            // pf_take only fires with remain==0 when cur_full, so it never
            // collides with the decrement above.
            if (pf_take) begin
                cur_full   <= 1'b1;
                cur_color  <= pf_color;
                cur_remain <= pf_count;
            end else if (run_end) begin
                cur_full <= 1'b0;
            end
        end
    end
endmodule
